// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// MDU_DIV_EN: when defined, DIVU/DIV are legal and the divider step is built.
package mdu_pkg;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MADDU = 3'b010;
    localparam logic [2:0] OP_MADD  = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return op <= OP_DIV;
`else
        return op <= OP_MADD;
`endif
    endfunction

    function automatic logic op_is_acc(input logic [2:0] op);
        return (op == OP_MADDU) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// MDU_DIV_EN: when undefined the divide path is not built.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opd,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [XLEN:0]     upper;
    logic [2*XLEN-1:0] mul_nxt;

    // acc = {partial product, remaining multiplier bits}
    always_comb begin
        upper   = {1'b0, acc[2*XLEN-1:XLEN]}
                + {1'b0, (acc[0] ? opd : {XLEN{1'b0}})};
        mul_nxt = {upper, acc[XLEN-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [XLEN:0]     top;
    logic [XLEN-1:0]   diff;
    logic              ge;
    logic [2*XLEN-1:0] div_nxt;

    // acc = {remainder, dividend bits becoming quotient bits}
    always_comb begin
        top     = acc[2*XLEN-1:XLEN-1];
        ge      = top >= {1'b0, opd};
        diff    = top[XLEN-1:0] - opd;
        div_nxt = ge ? {diff, acc[XLEN-2:0], 1'b1}
                     : {top[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        acc_nxt = (mode == MODE_DIV) ? div_nxt : mul_nxt;
    end
`else
    always_comb begin
        acc_nxt = (mode == MODE_DIV) ? acc : mul_nxt;
    end
`endif

endmodule

// File: rtl/iter_mdu_hilo.sv
// Iterative multiply/divide unit with Hi/Lo registers, XLEN+1 cycles per op.
// MDU_DIV_EN: when defined, DIVU/DIV are accepted; otherwise they are ignored.
module iter_mdu_hilo
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              mode_q, mode_d, macc_q, macc_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [2*XLEN-1:0] step_acc, prod_s, acc_sum;
    logic [XLEN-1:0]   abs_a, abs_b, quo, rem;

    mdu_step #(.XLEN(XLEN)) u_step (
        .mode    (mode_q),
        .acc     (acc_q),
        .opd     (opd_q),
        .acc_nxt (step_acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mode_d  = mode_q;
        macc_d  = macc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        abs_a   = (op[0] && a[XLEN-1]) ? -a : a;
        abs_b   = (op[0] && b[XLEN-1]) ? -b : b;
        prod_s  = neg_q ? -acc_q : acc_q;
        acc_sum = {hi_q, lo_q} + prod_s;
        // Zero divisor leaves |a| as remainder; only the quotient needs forcing.
        quo     = dz_q ? {XLEN{1'b1}}
                       : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
        rem     = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        unique case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start && !flush && op_legal(op)) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(XLEN - 1);
                    mode_d  = op[2];
                    macc_d  = op_is_acc(op);
                    neg_d   = op[0] & (a[XLEN-1] ^ b[XLEN-1]);
                    rneg_d  = op[0] & a[XLEN-1];
                    dz_d    = op[2] && (b == '0);
                    acc_d   = {{XLEN{1'b0}}, (op[2] ? abs_a : abs_b)};
                    opd_d   = op[2] ? abs_b : abs_a;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (mode_q == MODE_DIV) {hi_d, lo_d} = {rem, quo};
                    else if (macc_q)        {hi_d, lo_d} = acc_sum;
                    else                    {hi_d, lo_d} = prod_s;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mode_q  <= MODE_MUL;
            macc_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mode_q  <= mode_d;
            macc_q  <= macc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_iter_mdu_hilo.sv
// Self-checking bench for iter_mdu_hilo (XLEN=32).
// Follows MDU_DIV_EN to pick divide expectations.
module tb_iter_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush, mthi, mtlo;
    logic [2:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    iter_mdu_hilo #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] h,
                                          input logic [31:0] l);
        longint sx, sy;
        int q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_MULTU: p = {32'b0, x} * {32'b0, y};
            OP_MULT:  p = 64'(sx * sy);
            OP_MADDU: p = {h, l} + {32'b0, x} * {32'b0, y};
            OP_MADD:  p = {h, l} + 64'(sx * sy);
            OP_DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    p = {32'h0, 32'h8000_0000};
                else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    p = {32'(r), 32'(q)};
                end
            end
        endcase
        return p;
    endfunction

    task automatic launch(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic [63:0] e;
        e = model(o, x, y, m_hi, m_lo);
        {m_hi, m_lo} = e;
        sb.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        mthi = h; mtlo = l; wdata = d;
        if (h) m_hi = d;
        if (l) m_lo = d;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int bcnt, output bit seen);
        bcnt = 0;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++;
        if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    endtask

    task automatic test_multu();
        int bc; bit seen; logic [63:0] e;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(60, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin errors++; $display("FAIL multu_done: got none expected pulse"); end
        checks++;
        if (bc != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
        checks++;
        if ({hi, lo} !== e) begin errors++; $display("FAIL multu_result: got %h expected %h", {hi, lo}, e); end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL multu_const: got %h expected fffffffe00000001", {hi, lo});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back();
        int bc; bit seen; logic [63:0] e;
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(60, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {hi, lo} !== e || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++; $display("FAIL mult_result: got %h expected %h", {hi, lo}, e);
        end
        launch(OP_MULTU, 32'd12345, 32'd6789);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
        wait_done(60, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {hi, lo} !== e) begin
            errors++; $display("FAIL b2b_result: got %h expected %h", {hi, lo}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_maddu();
        int bc; bit seen; logic [63:0] e;
        mt_write(1'b0, 1'b1, 32'hFFFF_FFFF);
        mt_write(1'b1, 1'b0, 32'h0);
        checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL mt_write: got %h expected %h", {hi, lo}, {m_hi, m_lo});
        end
        launch(OP_MADDU, 32'd1, 32'd1);
        wait_done(60, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {hi, lo} !== e || {hi, lo} !== 64'h0000_0001_0000_0000) begin
            errors++; $display("FAIL maddu_result: got %h expected %h", {hi, lo}, e);
        end
        @(negedge clk);
        mthi = 1'b1; wdata = 32'd5; m_hi = 32'd5;
        launch(OP_MADD, 32'hFFFF_FFFF, 32'd2);
        mthi = 1'b0;
        wait_done(60, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {hi, lo} !== e) begin
            errors++; $display("FAIL madd_same_edge: got %h expected %h", {hi, lo}, e);
        end
        @(negedge clk);
        mt_write(1'b1, 1'b1, 32'hA5A5_5A5A);
        checks++;
        if (hi !== 32'hA5A5_5A5A || lo !== 32'hA5A5_5A5A) begin
            errors++; $display("FAIL mt_both: got %h expected a5a55a5aa5a55a5a", {hi, lo});
        end
    endtask

    task automatic test_div();
        int bc; bit seen; logic [63:0] e;
        logic [2:0] ill;
`ifdef MDU_DIV_EN
        logic [31:0] da[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] db[4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [2:0]  dop[4] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        for (int i = 0; i < 4; i++) begin
            launch(dop[i], da[i], db[i]);
            wait_done(60, bc, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || {hi, lo} !== e) begin
                errors++; $display("FAIL div_%0d: got %h expected %h", i, {hi, lo}, e);
            end
            @(negedge clk);
        end
        checks++;
        if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_zero_signed: got %h expected fffffff9ffffffff", {hi, lo});
        end
`else
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? OP_DIV : OP_DIVU;
            a = (i == 0) ? 32'hFFFF_FFF9 : 32'd7;
            b = (i == 0) ? 32'd2 : 32'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL div_off_busy_%0d: got %b expected 0", i, busy); end
            wait_done(5, bc, seen);
            checks++;
            if (seen || {hi, lo} !== {m_hi, m_lo}) begin
                errors++; $display("FAIL div_off_hilo_%0d: got %h expected %h", i, {hi, lo}, {m_hi, m_lo});
            end
        end
`endif
        for (int i = 6; i < 8; i++) begin
            ill = 3'(i);
            op = ill; a = 32'd3; b = 32'd4; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || {hi, lo} !== {m_hi, m_lo}) begin
                errors++; $display("FAIL illegal_op_%0d: got busy=%b hilo=%h expected 0 %h",
                                   i, busy, {hi, lo}, {m_hi, m_lo});
            end
        end
    endtask

    task automatic test_flush();
        int bc; bit seen;
        op = OP_MULT; a = 32'd5; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        wait_done(40, bc, seen);
        checks++;
        if (seen || bc != 0 || {hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL flush_nodone: got done=%b busy_cycles=%0d hilo=%h expected 0 0 %h",
                               seen, bc, {hi, lo}, {m_hi, m_lo});
        end
        op = OP_MULTU; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_same: got busy=%b expected 0", busy); end
    endtask

    task automatic test_start_busy();
        int bc; bit seen; logic [63:0] e;
        launch(OP_MULTU, 32'd2, 32'd3);
        repeat (5) @(negedge clk);
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        op = OP_MULTU; a = 32'd100; b = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_done(60, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {hi, lo} !== e) begin
            errors++; $display("FAIL start_busy_result: got %h expected %h", {hi, lo}, e);
        end
        @(negedge clk);
        wait_done(40, bc, seen);
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++; $display("FAIL start_busy_queued: got done=%b busy=%b expected 0 0", seen, busy);
        end
    endtask

    task automatic test_rst_mid();
        op = OP_MULTU; a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL rst_mid: got busy=%b done=%b hi=%h lo=%h expected all 0",
                               busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_multu();
        test_back_to_back();
        test_maddu();
        test_div();
        test_flush();
        test_start_busy();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
